multicycle_alu: RTL and testbench

- Execution unit that consumes the 4-bit ALUOperation code produced by the ALU control decoder. It performs the selected operation on the register-file operands and returns a registered result.
- Logic, add and LUI operations complete in one cycle. SLL and SRL use a serial shifter that moves one bit per cycle, with a start/busy/done handshake toward the datapath control FSM.
- Sits between the ALU control decoder, the operand muxes and the write-back path.

---
 rtl/multicycle_alu.sv | 138 +++++++++++++
 tb/tb_multicycle_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Execution unit: single-cycle logic/add/LUI plus a one-bit-per-cycle serial
// shifter for SLL/SRL, with a start/busy/done handshake and registered flags.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero,
    output logic               Error
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_LUI = 4'b0111;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam int HALF = WIDTH / 2;

    logic [0:0]         state_q,  state_d;
    logic [WIDTH-1:0]   shreg_q,  shreg_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic               left_q,   left_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic               error_q,  error_d;
    logic               done_q,   done_d;

    logic [WIDTH-1:0]   single_res_s;
    logic               invalid_s;
    logic               is_shift_s;

    // Single-cycle operation result; invalid codes yield zero with the error flag.
    always_comb begin
        single_res_s = '0;
        invalid_s    = 1'b0;
        case (ALUOperation)
            OP_AND:  single_res_s = A & B;
            OP_OR:   single_res_s = A | B;
            OP_NOR:  single_res_s = ~(A | B);
            OP_ADD:  single_res_s = A + B;
            OP_LUI:  single_res_s = {B[HALF-1:0], {(WIDTH-HALF){1'b0}}};
            default: invalid_s    = 1'b1;
        endcase
    end

    assign is_shift_s = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);

    // Next-state logic for the IDLE/SHIFT controller and the result registers.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        result_d = result_q;
        zero_d   = zero_q;
        error_d  = error_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_s) begin
                        state_d = ST_SHIFT;
                        shreg_d = B;
                        cnt_d   = shamt;
                        left_d  = (ALUOperation == OP_SLL);
                    end else begin
                        result_d = single_res_s;
                        zero_d   = (single_res_s == '0);
                        error_d  = invalid_s;
                        done_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Counter reaching zero means the register already holds the answer.
                if (cnt_q != '0) begin
                    shreg_d = left_q ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    result_d = shreg_q;
                    zero_d   = (shreg_q == '0);
                    error_d  = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: inputs driven and outputs sampled on the
// falling edge, so each sample shows the registered state of that cycle.
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ALUOperation;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Error;

    int checks   = 0;
    int failures = 0;

    multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1 || Error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b res=%h zero=%b err=%b, want 0 0 00000000 1 0",
                     busy, done, ALUResult, Zero, Error);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_N: busy=%b want 0", busy); end
        tick(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1 || Error !== 1'b0) begin
            failures++;
            $display("FAIL add_result: done=%b busy=%b res=%h zero=%b err=%b, want 1 0 00000000 1 0",
                     done, busy, ALUResult, Zero, Error);
        end
        tick();
        checks++;
        if (done !== 1'b0 || ALUResult !== 32'h0) begin
            failures++;
            $display("FAIL add_hold: done=%b res=%h, want 0 00000000", done, ALUResult);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'b0010, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd0);
        tick();
        checks++;
        if (done !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL b2b_nor: done=%b res=%h zero=%b, want 1 00000000 1", done, ALUResult, Zero);
        end
        issue(4'b0111, 32'h0, 32'h0000_1234, 5'd0);
        tick(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || ALUResult !== 32'h1234_0000 || Zero !== 1'b0 || Error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_lui: done=%b res=%h zero=%b err=%b, want 1 12340000 0 0",
                     done, ALUResult, Zero, Error);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL b2b_after: done=%b want 0", done); end
    endtask

    task automatic test_sll();
        int bad;
        issue(4'b0101, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            tick(); start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL sll31_busy: %0d bad cycles in N+1..N+32, want 0", bad); end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ALUResult !== 32'h8000_0000 || Zero !== 1'b0 || Error !== 1'b0) begin
            failures++;
            $display("FAIL sll31_result: done=%b busy=%b res=%h zero=%b err=%b, want 1 0 80000000 0 0",
                     done, busy, ALUResult, Zero, Error);
        end
        issue(4'b0101, 32'h0, 32'h0000_0001, 5'd0);
        tick(); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL sll0_busy: busy=%b done=%b, want 1 0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ALUResult !== 32'h0000_0001) begin
            failures++;
            $display("FAIL sll0_result: done=%b busy=%b res=%h, want 1 0 00000001", done, busy, ALUResult);
        end
    endtask

    task automatic test_srl_ignored();
        int bad;
        int dones;
        issue(4'b0110, 32'h0, 32'h8000_0000, 5'd4);
        bad = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) issue(4'b0011, 32'h0000_0001, 32'h0000_0001, 5'd1);
            else start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL srl_busy: %0d bad cycles in N+1..N+5, want 0", bad); end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ALUResult !== 32'h0800_0000 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL srl_result: done=%b busy=%b res=%h zero=%b, want 1 0 08000000 0",
                     done, busy, ALUResult, Zero);
        end
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || ALUResult !== 32'h0800_0000) begin
            failures++;
            $display("FAIL srl_no_extra_done: extra dones=%0d res=%h, want 0 08000000", dones, ALUResult);
        end
    endtask

    task automatic test_invalid();
        issue(4'b1001, 32'h0000_0005, 32'h0000_0007, 5'd3);
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || Error !== 1'b1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL invalid_op: done=%b busy=%b err=%b res=%h zero=%b, want 1 0 1 00000000 1",
                     done, busy, Error, ALUResult, Zero);
        end
        issue(4'b0001, 32'h0000_0001, 32'h0000_0002, 5'd0);
        tick(); start = 1'b0;
        checks++;
        if (done !== 1'b1 || Error !== 1'b0 || ALUResult !== 32'h0000_0003 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL invalid_then_or: done=%b err=%b res=%h zero=%b, want 1 0 00000003 0",
                     done, Error, ALUResult, Zero);
        end
    endtask

    task automatic test_reset_mid_shift();
        int dones;
        issue(4'b0101, 32'h0, 32'h0000_0001, 5'd20);
        for (int k = 1; k <= 5; k++) begin
            tick(); start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || ALUResult !== 32'h0000_0003) begin
            failures++;
            $display("FAIL rst_mid_pre: busy=%b res=%h, want 1 00000003", busy, ALUResult);
        end
        reset = 1'b1;
        tick(); reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1 || Error !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state: busy=%b done=%b res=%h zero=%b err=%b, want 0 0 00000000 1 0",
                     busy, done, ALUResult, Zero, Error);
        end
        dones = 0;
        for (int k = 7; k <= 25; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++; $display("FAIL rst_mid_no_done: %0d cycles with done/busy in N+7..N+25, want 0", dones);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ALUOperation = 4'b0000;
        A = 32'h0; B = 32'h0; shamt = 5'd0;
        test_reset();
        test_add();
        test_back_to_back();
        test_sll();
        test_srl_ignored();
        test_invalid();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
